// File: rtl/detector_seq_pkg.sv
// Shared types and sizing for the detector self-test sequencer.
package detector_seq_pkg;

  localparam int SEQ_LEN_MAX = 16;
  localparam int SEQ_CNT_W   = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/detector_sequencer_shifter.sv
// Pattern load/shift register feeding the detector w input, with bit index and last-bit flag.
module pattern_shifter
  import detector_seq_pkg::*;
#(
  parameter int LEN_MAX = SEQ_LEN_MAX,
  parameter int CNT_W   = SEQ_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [LEN_MAX-1:0]         pattern,
  input  logic [CNT_W-1:0]           len_q,
  input  logic                       shift,
  input  logic                       step,
  output logic                       w_out,
  output logic [$clog2(LEN_MAX)-1:0] idx,
  output logic                       last
);

  localparam int IDX_W = $clog2(LEN_MAX);

  logic [LEN_MAX-1:0] sr;

  // w_out is a flop: the next bit is launched on the edge before the cycle that drives it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr    <= '0;
      w_out <= 1'b0;
      idx   <= '0;
    end else if (load) begin
      sr    <= pattern;
      w_out <= 1'b0;
      idx   <= '0;
    end else begin
      if (shift) begin
        w_out <= sr[0];
        sr    <= sr >> 1;
      end else begin
        w_out <= 1'b0;
      end
      if (step) idx <= idx + IDX_W'(1);
    end
  end

  assign last = (CNT_W'(idx) == (len_q - CNT_W'(1)));

endmodule

// File: rtl/detector_sequencer.sv
// Self-test sequencer: clears the detector, shifts a pattern in, captures z per bit.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one-cycle fsm_clr pulse to the detector, w_out=0
// RUN   | drive pattern bit idx, capture z for bit idx-1
// DRAIN | w_out=0, capture z for the last bit
// DONE  | one-cycle done pulse, results valid
module detector_sequencer
  import detector_seq_pkg::*;
#(
  parameter int LEN_MAX = SEQ_LEN_MAX,
  parameter int CNT_W   = SEQ_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_MAX-1:0] pattern,
  input  logic [CNT_W-1:0]   length,
  input  logic               z_in,
  output logic               w_out,
  output logic               fsm_clr,
  output logic               busy,
  output logic               done,
  output logic [LEN_MAX-1:0] hit_map,
  output logic [CNT_W-1:0]   hit_count
);

  localparam int IDX_W = $clog2(LEN_MAX);

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_CLEAR = 3'(CLEAR);
  localparam logic [2:0] ST_RUN   = 3'(RUN);
  localparam logic [2:0] ST_DRAIN = 3'(DRAIN);
  localparam logic [2:0] ST_DONE  = 3'(DONE);

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] len_q, len_clamped;
  logic             accept, shift, step, last, cap_en;
  logic [IDX_W-1:0] idx, cap_pos;

  assign len_clamped = (length > CNT_W'(LEN_MAX)) ? CNT_W'(LEN_MAX) : length;
  assign accept      = (state == ST_IDLE) && start;
  assign shift       = ((state == ST_CLEAR) && (len_q != '0)) || ((state == ST_RUN) && !last);
  assign step        = (state == ST_RUN) && !last;
  assign busy        = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_CLEAR;
      ST_CLEAR: state_nx = (len_q == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last) state_nx = ST_DRAIN;
      ST_DRAIN: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // z lags w by one cycle, so RUN cycle idx observes the response to bit idx-1
  always_comb begin
    cap_en  = 1'b0;
    cap_pos = '0;
    if ((state == ST_RUN) && (idx != '0)) begin
      cap_en  = 1'b1;
      cap_pos = idx - IDX_W'(1);
    end else if (state == ST_DRAIN) begin
      cap_en  = 1'b1;
      cap_pos = IDX_W'(len_q - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      fsm_clr   <= 1'b0;
      done      <= 1'b0;
      len_q     <= '0;
      hit_map   <= '0;
      hit_count <= '0;
    end else begin
      state   <= state_nx;
      fsm_clr <= (state_nx == ST_CLEAR);
      done    <= (state_nx == ST_DONE);
      if (accept) begin
        len_q     <= len_clamped;
        hit_map   <= '0;
        hit_count <= '0;
      end else if (cap_en) begin
        hit_map[cap_pos] <= z_in;
        hit_count        <= hit_count + CNT_W'(z_in);
      end
    end
  end

  pattern_shifter #(
    .LEN_MAX (LEN_MAX),
    .CNT_W   (CNT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .pattern (pattern),
    .len_q   (len_q),
    .shift   (shift),
    .step    (step),
    .w_out   (w_out),
    .idx     (idx),
    .last    (last)
  );

endmodule

// File: tb/tb_detector_sequencer.sv
// Bench for detector_sequencer: run-level model checked every cycle, plus directed literal checks.
module tb_detector_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic        z_in;
  logic        w_out, fsm_clr, busy, done;
  logic [15:0] hit_map;
  logic [4:0]  hit_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  detector_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .length    (length),
    .z_in      (z_in),
    .w_out     (w_out),
    .fsm_clr   (fsm_clr),
    .busy      (busy),
    .done      (done),
    .hit_map   (hit_map),
    .hit_count (hit_count)
  );

  // z source: loopback (w delayed one clk) or a 101 overlapping sequence detector
  logic       det_mode = 1'b0;
  logic       z_loop;
  logic [2:0] det_state;

  always @(posedge clk or posedge reset) begin
    if (reset) z_loop <= 1'b0;
    else       z_loop <= w_out;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) det_state <= 3'd2;
    else if (fsm_clr) det_state <= 3'd0;
    else begin
      case (det_state)
        3'd0:    det_state <= w_out ? 3'd1 : 3'd0;
        3'd1:    det_state <= w_out ? 3'd1 : 3'd2;
        3'd2:    det_state <= w_out ? 3'd3 : 3'd0;
        default: det_state <= w_out ? 3'd1 : 3'd2;
      endcase
    end
  end

  assign z_in = det_mode ? (det_state == 3'd3) : z_loop;

  // Run-level model: phase = cycles since start accept, -1 when idle
  function automatic int total_of(input int l);
    return (l == 0) ? 2 : l + 3;
  endfunction

  function automatic logic [15:0] golden_map(input logic [15:0] p, input int l, input logic dm);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < l; i++) begin
      if (!dm) m[i] = p[i];
      else if (i >= 2) m[i] = p[i] & ~p[i-1] & p[i-2];
    end
    return m;
  endfunction

  function automatic int popcount(input logic [15:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  int          phase = -1;
  int          m_len = 0;
  logic [15:0] m_pat = '0;
  logic [15:0] exp_map = '0;
  int          exp_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase   <= -1;
      exp_map <= '0;
      exp_cnt <= 0;
    end else if (phase < 0) begin
      if (start) begin
        m_len   <= (int'(length) > 16) ? 16 : int'(length);
        m_pat   <= pattern;
        phase   <= 1;
        exp_map <= '0;
        exp_cnt <= 0;
      end
    end else if (phase >= total_of(m_len)) begin
      phase <= -1;
    end else begin
      phase <= phase + 1;
      if (phase + 1 == total_of(m_len)) begin
        exp_map <= golden_map(m_pat, m_len, det_mode);
        exp_cnt <= popcount(golden_map(m_pat, m_len, det_mode));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every wait goes through tick(): advance to the falling edge, then compare against the model
  task automatic tick();
    int  tot;
    logic exp_w;
    @(negedge clk);
    tot   = total_of(m_len);
    exp_w = 1'b0;
    if (phase >= 2 && phase <= m_len + 1) exp_w = m_pat[phase-2];
    chk("busy",    32'(busy),    32'(phase >= 1));
    chk("fsm_clr", 32'(fsm_clr), 32'(phase == 1));
    chk("done",    32'(done),    32'(phase == tot));
    chk("w_out",   32'(w_out),   32'(exp_w));
    if (phase < 0 || phase == 1 || phase == tot) begin
      chk("hit_map",   32'(hit_map),   32'(exp_map));
      chk("hit_count", 32'(hit_count), 32'(exp_cnt));
    end
  endtask

  task automatic run(input logic [15:0] pat, input logic [4:0] len, input int pulse_at,
                     output int done_at, output int busy_n, output int clr_n,
                     output int done_n, output int w_n);
    int n;
    pattern = pat;
    length  = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    n = 1;
    done_at = 0; busy_n = 0; clr_n = 0; done_n = 0; w_n = 0;
    while (n <= 40) begin
      if (busy)    busy_n++;
      if (fsm_clr) clr_n++;
      if (w_out)   w_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = n;
      end
      if (done_at != 0 && n >= done_at + 2) break;
      if (n == pulse_at) begin
        start   = 1'b1;
        pattern = ~pat;
        length  = 5'd3;
      end else if (n == pulse_at + 1) begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    if (done_at == 0) chk("run_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int da, bn, cn, dn, wn, gap;
    reset = 1'b1; start = 1'b0; pattern = '0; length = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_w",     32'(w_out), 32'd0);
    chk("rst_map",   32'(hit_map), 32'd0);
    chk("rst_count", 32'(hit_count), 32'd0);

    // 1) full-length pattern
    run(16'hA5C3, 5'd16, -10, da, bn, cn, dn, wn);
    chk("t1_done_at", 32'(da), 32'd19);
    chk("t1_map",     32'(hit_map), 32'hA5C3);
    chk("t1_count",   32'(hit_count), 32'd8);

    // 2) short pattern, bits above length stay zero
    run(16'hFFFF, 5'd5, -10, da, bn, cn, dn, wn);
    chk("t2_map",   32'(hit_map), 32'h001F);
    chk("t2_count", 32'(hit_count), 32'd5);
    chk("t2_busy_cycles", 32'(bn), 32'd8);

    // 3) zero length: CLEAR then DONE
    run(16'hFFFF, 5'd0, -10, da, bn, cn, dn, wn);
    chk("t3_done_at", 32'(da), 32'd2);
    chk("t3_map",     32'(hit_map), 32'd0);
    chk("t3_count",   32'(hit_count), 32'd0);
    chk("t3_w_high",  32'(wn), 32'd0);

    // 4) clamped length, start pulse and input changes mid-run
    run(16'hA5C3, 5'd20, 8, da, bn, cn, dn, wn);
    chk("t4_done_at", 32'(da), 32'd19);
    chk("t4_done_n",  32'(dn), 32'd1);
    chk("t4_map",     32'(hit_map), 32'hA5C3);
    chk("t4_count",   32'(hit_count), 32'd8);
    tick();

    // start held high: back-to-back runs separated by one idle cycle
    pattern = 16'h0006; length = 5'd2; start = 1'b1;
    da = 0;
    for (int i = 0; i < 20 && da == 0; i++) begin tick(); if (done) da = 1; end
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); gap++;
      if (fsm_clr) break;
    end
    chk("t_hold_gap", 32'(gap), 32'd2);
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t_hold_map", 32'(hit_map), 32'h0002);

    // 5) asynchronous reset on RUN cycle 4
    pattern = 16'hA5C3; length = 5'd16; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 6; n++) tick();
    #2 reset = 1'b1;
    #1;
    chk("t5_busy",  32'(busy), 32'd0);
    chk("t5_clr",   32'(fsm_clr), 32'd0);
    chk("t5_w",     32'(w_out), 32'd0);
    chk("t5_done",  32'(done), 32'd0);
    chk("t5_map",   32'(hit_map), 32'd0);
    chk("t5_count", 32'(hit_count), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 25; i++) begin tick(); if (done) dn++; end
    chk("t5_no_done", 32'(dn), 32'd0);
    run(16'h3C5A, 5'd12, -10, da, bn, cn, dn, wn);
    chk("t5_rerun_map", 32'(hit_map), 32'h0C5A);
    chk("t5_rerun_count", 32'(hit_count), 32'd6);

    // 6) detector in the loop
    det_mode = 1'b1;
    tick();
    run(16'h0000, 5'd8, -10, da, bn, cn, dn, wn);
    chk("t6_clr_pulses", 32'(cn), 32'd1);
    chk("t6_count",      32'(hit_count), 32'd0);
    run(16'h0015, 5'd6, -10, da, bn, cn, dn, wn);
    chk("t6_map_101",   32'(hit_map), 32'h0014);
    chk("t6_count_101", 32'(hit_count), 32'd2);
    chk("t6_clr_101",   32'(cn), 32'd1);
    run(16'hB6D5, 5'd16, -10, da, bn, cn, dn, wn);
    chk("t6_count_long", 32'(hit_count), 32'(popcount(golden_map(16'hB6D5, 16, 1'b1))));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
